// File: rtl/vga_pkg.sv
// Shared constants for the VGA FIFO reader: default 640x480@60 raster timing,
// the pixel word width and the reader state encoding.
package vga_pkg;

  localparam int RGB565_W = 16;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic {
    WAIT_FILL = 1'b0,
    RUN       = 1'b1
  } rd_state_t;

endpackage

// File: rtl/vga_fifo_reader_if.sv
// Read-side handshake of the SDRAM display FIFO (normal mode: data valid the
// cycle after a read request).
interface vga_fifo_reader_if
  import vga_pkg::*;
#(
  parameter int DATA_W  = RGB565_W,
  parameter int USEDW_W = 11
) ();

  logic               r_fifo_rreq;
  logic [DATA_W-1:0]  sys_r_data;
  logic [USEDW_W-1:0] r_fifo_rusedw;

  modport master (
    output r_fifo_rreq,
    input  sys_r_data,
    input  r_fifo_rusedw
  );

  modport slave (
    input  r_fifo_rreq,
    output sys_r_data,
    output r_fifo_rusedw
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Free-running raster counters and region decode (active area, sync pulses,
// last clock of the frame, first clock of the frame).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic clk,
  input  logic rst,
  output logic act,
  output logic hs_n,
  output logic vs_n,
  output logic frame_end,
  output logic origin
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_CW    = $clog2(H_TOTAL);
  localparam int V_CW    = $clog2(V_TOTAL);

  logic [H_CW-1:0] h_cnt_reg;
  logic [V_CW-1:0] v_cnt_reg;
  logic            h_last;
  logic            v_last;

  assign h_last = (int'(h_cnt_reg) == H_TOTAL - 1);
  assign v_last = (int'(v_cnt_reg) == V_TOTAL - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_last) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 1'b1;
    end
  end

  // Integer compares keep the decode exact even when a boundary equals 2**width.
  assign act  = (int'(h_cnt_reg) < H_ACTIVE) && (int'(v_cnt_reg) < V_ACTIVE);
  assign hs_n = !((int'(h_cnt_reg) >= H_ACTIVE + H_FP) &&
                  (int'(h_cnt_reg) <  H_ACTIVE + H_FP + H_SYNC));
  assign vs_n = !((int'(v_cnt_reg) >= V_ACTIVE + V_FP) &&
                  (int'(v_cnt_reg) <  V_ACTIVE + V_FP + V_SYNC));
  assign frame_end = h_last && v_last;
  assign origin    = (h_cnt_reg == '0) && (v_cnt_reg == '0);

endmodule

// File: rtl/vga_fifo_reader.sv
// Display-side FIFO consumer: pulls one word per active pixel once the FIFO has
// prefilled at a frame boundary, and blanks the rest of a frame on underflow.
module vga_fifo_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int DATA_W      = RGB565_W,
  parameter int USEDW_W     = 11,
  parameter int START_LEVEL = 256
) (
  input  logic                clk,
  input  logic                rst,
  vga_fifo_reader_if.master   fifo,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_de,
  output logic [DATA_W-1:0]   vga_rgb,
  output logic                frame_start,
  output logic [15:0]         underflow_cnt
);

  localparam logic [USEDW_W-1:0] START_LVL = USEDW_W'(START_LEVEL);

  logic      act;
  logic      hs_n;
  logic      vs_n;
  logic      frame_end;
  logic      origin;

  rd_state_t state_reg;
  rd_state_t state_next;
  logic      rreq;
  logic      rreq_reg;
  logic      underflow;
  logic [15:0] underflow_cnt_reg;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .act       (act),
    .hs_n      (hs_n),
    .vs_n      (vs_n),
    .frame_end (frame_end),
    .origin    (origin)
  );

  always_comb begin
    state_next = state_reg;
    rreq       = 1'b0;
    underflow  = 1'b0;
    case (state_reg)
      WAIT_FILL: begin
        // Only a frame boundary may start streaming, so pixel 0 is always word 0.
        if (frame_end && (fifo.r_fifo_rusedw >= START_LVL)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (act) begin
          if (fifo.r_fifo_rusedw != '0) begin
            rreq = 1'b1;
          end else begin
            underflow  = 1'b1;
            state_next = WAIT_FILL;
          end
        end
      end
      default: state_next = WAIT_FILL;
    endcase
  end

  assign fifo.r_fifo_rreq = rreq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= WAIT_FILL;
      rreq_reg          <= 1'b0;
      underflow_cnt_reg <= '0;
      vga_hs            <= 1'b1;
      vga_vs            <= 1'b1;
      vga_de            <= 1'b0;
      frame_start       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rreq_reg    <= rreq;
      vga_hs      <= hs_n;
      vga_vs      <= vs_n;
      vga_de      <= act;
      frame_start <= act && origin;
      if (underflow && (underflow_cnt_reg != 16'hFFFF)) begin
        underflow_cnt_reg <= underflow_cnt_reg + 16'd1;
      end
    end
  end

  // FIFO data lands the cycle after the request, the same cycle as the registered DE.
  assign vga_rgb       = rreq_reg ? fifo.sys_r_data : '0;
  assign underflow_cnt = underflow_cnt_reg;

endmodule

// File: tb/tb_vga_fifo_reader.sv
// Bench for vga_fifo_reader on a tiny 14x7 raster with a queue-based FIFO and a
// frame-level model of the expected raster, reads and underflow count.
module tb_vga_fifo_reader;
  import vga_pkg::*;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int SL = 4;
  localparam int DW = 16;
  localparam int UW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vga_hs, vga_vs, vga_de, frame_start;
  logic [DW-1:0] vga_rgb;
  logic [15:0]   underflow_cnt;

  vga_fifo_reader_if #(.DATA_W(DW), .USEDW_W(UW)) fifo ();

  vga_fifo_reader #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .DATA_W (DW), .USEDW_W (UW), .START_LEVEL (SL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo          (fifo),
    .vga_hs        (vga_hs),
    .vga_vs        (vga_vs),
    .vga_de        (vga_de),
    .vga_rgb       (vga_rgb),
    .frame_start   (frame_start),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] fifo_q[$];
  int          tick;
  bit          exp_run;
  int          exp_uf;
  bit          e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_fs = 1'b0;
  logic [15:0] e_rgb = '0;
  bit          rreq_seen;
  int          errors = 0;
  int          checks = 0;
  int          st_rreq, st_de, st_hs_low, st_vs_low, st_rgb_nz;
  logic [15:0] fs_rgb;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic clear_stats();
    st_rreq = 0; st_de = 0; st_hs_low = 0; st_vs_low = 0; st_rgb_nz = 0;
    fs_rgb = '0;
  endtask

  // One pixel clock: FIFO responds after the edge, outputs are checked at the
  // falling edge, then the model predicts the next cycle.
  task automatic step(input bit r);
    int h, v;
    bit act, e_rreq;
    @(posedge clk);
    #1;
    rst = r;
    if (rreq_seen) begin
      if (fifo_q.size() > 0) begin
        fifo.sys_r_data = fifo_q.pop_front();
        $display("read word %04h, %0d left", fifo.sys_r_data, fifo_q.size());
      end else begin
        fifo.sys_r_data = 16'hBAD0;
      end
    end
    fifo.r_fifo_rusedw = UW'(fifo_q.size());
    @(negedge clk);
    chk("vga_hs", vga_hs, e_hs);
    chk("vga_vs", vga_vs, e_vs);
    chk("vga_de", vga_de, e_de);
    chk("vga_rgb", vga_rgb, e_rgb);
    chk("frame_start", frame_start, e_fs);
    chk("underflow_cnt", underflow_cnt, exp_uf);
    st_rreq   += int'(fifo.r_fifo_rreq);
    st_de     += int'(vga_de);
    st_hs_low += int'(!vga_hs);
    st_vs_low += int'(!vga_vs);
    if (vga_rgb != '0) st_rgb_nz++;
    if (frame_start) fs_rgb = vga_rgb;

    h = tick % HT;
    v = tick / HT;
    act = (h < HA) && (v < VA);
    e_rreq = act && exp_run && (fifo_q.size() != 0);
    chk("r_fifo_rreq", fifo.r_fifo_rreq, e_rreq);
    rreq_seen = fifo.r_fifo_rreq;
    if (r) begin
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_rgb = '0;
      exp_run = 1'b0; exp_uf = 0; tick = 0;
    end else begin
      e_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
      e_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
      e_de  = act;
      e_fs  = (tick == 0);
      e_rgb = e_rreq ? fifo_q[0] : 16'h0000;
      if (exp_run && act && fifo_q.size() == 0) begin
        exp_run = 1'b0;
        if (exp_uf < 65535) exp_uf++;
      end else if (!exp_run && tick == FT - 1 && fifo_q.size() >= SL) begin
        exp_run = 1'b1;
      end
      tick = (tick + 1) % FT;
    end
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (tick != v * HT + h && n < 2 * FT) begin
      step(1'b0);
      n++;
    end
    chk("run_to_reached", tick, v * HT + h);
  endtask

  task automatic push_range(input int first, input int count);
    for (int i = 0; i < count; i++) fifo_q.push_back(16'(first + i));
  endtask

  initial begin
    logic [15:0] sat_want [3];
    sat_want[0] = 16'hFFFE; sat_want[1] = 16'hFFFF; sat_want[2] = 16'hFFFF;
    fifo.sys_r_data = '0;
    fifo.r_fifo_rusedw = '0;
    tick = 0; exp_run = 1'b0; exp_uf = 0; rreq_seen = 1'b0;
    clear_stats();

    repeat (3) step(1'b1);

    // Empty FIFO for three frames: raster runs, nothing is read.
    clear_stats();
    repeat (3 * FT) step(1'b0);
    chk("empty_rreq_cnt", st_rreq, 0);
    chk("empty_de_cnt", st_de, 96);
    chk("empty_hs_low", st_hs_low, 42);
    chk("empty_vs_low", st_vs_low, 42);
    chk("empty_rgb_nz", st_rgb_nz, 0);

    // Preload 64 words; streaming starts on the frame after the boundary.
    push_range(16'h0001, 64);
    repeat (FT) step(1'b0);
    clear_stats();
    repeat (FT) step(1'b0);
    chk("f4_rreq_cnt", st_rreq, 32);
    chk("f4_first_pixel", fs_rgb, 16'h0001);
    clear_stats();
    repeat (FT) step(1'b0);
    chk("f5_rreq_cnt", st_rreq, 32);
    chk("f5_first_pixel", fs_rgb, 16'h0021);

    // FIFO now empty: underflow on the first pixel, then 3 words is below threshold.
    clear_stats();
    run_to(0, 5);
    push_range(16'h0201, 3);
    run_to(0, 0);
    chk("f6_underflow_cnt", underflow_cnt, 1);
    chk("f6_rreq_cnt", st_rreq, 0);
    clear_stats();
    run_to(0, 5);
    chk("f7_wait_rreq_cnt", st_rreq, 0);
    push_range(16'h0204, 2);
    run_to(0, 0);

    // Five words: pixels 1..5 valid, pixel 6 underflows.
    clear_stats();
    run_to(0, 5);
    chk("f8_rreq_cnt", st_rreq, 5);
    chk("f8_rgb_nonzero", st_rgb_nz, 5);
    chk("f8_underflow_cnt", underflow_cnt, 2);
    push_range(16'h0301, 40);
    run_to(0, 0);

    // One-clock reset mid-line while streaming.
    run_to(3, 1);
    step(1'b1);
    step(1'b0);
    chk("rst_rgb", vga_rgb, 16'h0000);
    chk("rst_hs", vga_hs, 1'b1);
    chk("rst_vs", vga_vs, 1'b1);
    chk("rst_de", vga_de, 1'b0);
    chk("rst_underflow_cnt", underflow_cnt, 16'h0000);
    step(1'b0);
    chk("rst_origin_de", vga_de, 1'b1);
    chk("rst_origin_frame_start", frame_start, 1'b1);
    chk("rst_origin_rgb", vga_rgb, 16'h0000);

    // Starve frames, then preset the counter near its ceiling.
    repeat (3) begin
      run_to(0, 5);
      push_range(16'h0401, 4);
      run_to(0, 0);
    end
    force dut.underflow_cnt_reg = 16'hFFFD;
    #1;
    release dut.underflow_cnt_reg;
    exp_uf = 16'hFFFD;
    for (int f = 0; f < 3; f++) begin
      run_to(0, 5);
      chk("sat_underflow_cnt", underflow_cnt, sat_want[f]);
      push_range(16'h0501, 4);
      run_to(0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
